ay8913_bus_interface: RTL and testbench
=======================================

// Module: ay8913_bus_interface
// PURPOSE
//   Host-side bus front end that feeds the AY-3-8913 PSG core.
//   - Decodes the BDIR/BC1 bus protocol from asynchronous pins.
//   - Latches the register address and holds the 14 PSG registers R0..R13.
//   - Drives decoded register fields and an envelope-restart pulse to the tone, noise, envelope and mixer stages.
//   - Provides read-back of the register file.
// PARAMETERS
//   SYNC_STAGES  2        flops in each input synchronizer chain (>=2)
//   CHIP_ADDR    4'h0     value of data[7:4] required during address latch (A8/A9 chip select)
// PORTS
//   clk            in   1   system clock
//   rst_n          in   1   asynchronous active-low reset
//   bdir           in   1   bus direction pin (async)
//   bc1            in   1   bus control pin (async)
//   data_in        in   8   bus data pins (async)
//   data_out       out  8   read-back data
//   data_oe        out  1   1 = drive data_out onto bus
//   tone_period_a  out  12  {R1[3:0],R0}
//   tone_period_b  out  12  {R3[3:0],R2}
//   tone_period_c  out  12  {R5[3:0],R4}
//   noise_period   out  5   R6[4:0]
//   mixer_en_n     out  6   R7[5:0]: [2:0] tone A/B/C off, [5:3] noise A/B/C off
//   amp_a          out  5   R8[4:0]: bit4 = envelope mode
//   amp_b          out  5   R9[4:0]
//   amp_c          out  5   R10[4:0]
//   env_period     out  16  {R12,R11}
//   env_shape      out  4   R13[3:0]
//   env_restart    out  1   1-cycle pulse on every R13 write
//   wr_strobe      out  1   1-cycle pulse on every accepted write
//   wr_addr        out  4   address of the write flagged by wr_strobe
// BEHAVIOUR
//   Reset
//     - rst_n low clears immediately: sync chains, all register fields, addr_reg, addr_valid, data_out, data_oe, env_restart, wr_strobe, wr_addr.
//     - In-flight write is discarded.
//   Synchronization
//     - bdir, bc1 and data_in[7:0] each pass through SYNC_STAGES flops.
//     - mode = {bdir_s,bc1_s}; prev_mode is registered.
//   Mode FSM (states follow mode every cycle)
//     - INACTIVE=00, READ=01, WRITE=10, LATCH=11.
//     - Any state may go directly to any other (e.g. LATCH->WRITE).
//     - All actions fire only on entry (mode != prev_mode).
//   LATCH entry
//     - data_s[7:4]==CHIP_ADDR: addr_reg<=data_s[3:0], addr_valid<=1.
//     - Otherwise addr_valid<=0.
//   WRITE entry
//     - Write occurs only if addr_valid and addr_reg<=13.
//     - Store data_s masked to field width; unused bits are never stored.
//     - wr_strobe=1 and wr_addr=addr_reg on the following cycle.
//     - Exactly one write per WRITE phase; holding WRITE rewrites nothing.
//     - R13 writes also pulse env_restart, concurrent with wr_strobe and the new env_shape.
//     - Pulse fires even when the value is unchanged.
//     - addr_reg 14/15 or !addr_valid: ignored, no strobe.
//   Latency
//     - Pin change to register output = SYNC_STAGES+1 clk.
//   READ (level, registered)
//     - data_oe<=(mode==READ && addr_valid).
//     - data_out<=stored field zero-extended to 8b; addr 14/15 read 8'h00.
//     - Outside READ: data_oe=0, data_out=8'h00.
//   Simultaneous events
//     - Register fields update only via WRITE entry, so read-back in the same cycle returns the old value.
//     - The new value is visible on the next cycle.
// TESTING
//   T1: latch 8'h07, write 8'h3F -> mixer_en_n=6'h3F at SYNC_STAGES+1 clk after WRITE pins; wr_strobe 1 cycle, wr_addr=7.
//   T2: R0<=8'hAB, R1<=8'hFC -> tone_period_a=12'hCAB; read R1 -> data_oe=1, data_out=8'h0C.
//   T3: R13<=8'h0E twice (INACTIVE between) -> env_shape=4'hE; two separate 1-cycle env_restart pulses.
//   T4: CHIP_ADDR=0, latch 8'h17, write 8'h55 -> no field change, no wr_strobe; READ keeps data_oe=0.
//   T5: latch 8'h0E, write 8'hFF -> no change, no strobe; read -> data_oe=1, data_out=8'h00.
//   T6: R8<=8'h1F, then rst_n low mid-WRITE with pins held -> all outputs 0 at once; after release the held WRITE causes no write (addr_valid=0).

Source files
------------

// File: rtl/ay8913_bus_interface_if.sv
// ay8913_bus_interface_if: host-side BDIR/BC1 bus of the AY-3-8913 PSG
// Signals:
//   bdir, bc1  bus control pins, driven by the host (asynchronous to clk)
//   data_in    bus data pins, driven by the host (asynchronous to clk)
//   data_out   register read-back byte returned by the PSG
//   data_oe    1 = PSG drives data_out onto the bus
// Modports: master = host side, slave = PSG front end
interface ay8913_bus_interface_if;
    logic       bdir;
    logic       bc1;
    logic [7:0] data_in;
    logic [7:0] data_out;
    logic       data_oe;

    modport master (
        output bdir,
        output bc1,
        output data_in,
        input  data_out,
        input  data_oe
    );

    modport slave (
        input  bdir,
        input  bc1,
        input  data_in,
        output data_out,
        output data_oe
    );
endinterface

// File: rtl/ay8913_bus_interface.sv
// ay8913_bus_interface: bus front end and register file R0..R13 of the AY-3-8913 PSG
// Ports:
//   clk, rst_n         system clock, asynchronous active-low reset
//   bus (slave)        bdir/bc1/data_in pins in, data_out/data_oe read-back out
//   tone_period_a/b/c  12-bit tone periods {R1,R0}, {R3,R2}, {R5,R4}
//   noise_period       R6[4:0]
//   mixer_en_n         R7[5:0], active-low tone/noise enables
//   amp_a/b/c          R8..R10[4:0], bit 4 selects envelope mode
//   env_period         {R12,R11}
//   env_shape          R13[3:0]
//   env_restart        one-cycle pulse on every R13 write
//   wr_strobe, wr_addr one-cycle pulse and address of every accepted write
module ay8913_bus_interface #(
    parameter int         SYNC_STAGES = 2,
    parameter logic [3:0] CHIP_ADDR   = 4'h0
) (
    input  logic                   clk,
    input  logic                   rst_n,
    ay8913_bus_interface_if.slave  bus,
    output logic [11:0]            tone_period_a,
    output logic [11:0]            tone_period_b,
    output logic [11:0]            tone_period_c,
    output logic [4:0]             noise_period,
    output logic [5:0]             mixer_en_n,
    output logic [4:0]             amp_a,
    output logic [4:0]             amp_b,
    output logic [4:0]             amp_c,
    output logic [15:0]            env_period,
    output logic [3:0]             env_shape,
    output logic                   env_restart,
    output logic                   wr_strobe,
    output logic [3:0]             wr_addr
);

    typedef enum logic [1:0] {
        INACTIVE = 2'b00,
        READ     = 2'b01,
        WRITE    = 2'b10,
        LATCH    = 2'b11
    } mode_e;

    // Implemented bits of each register; R14/R15 do not exist and store nothing.
    localparam logic [7:0] FIELD_MASK [16] = '{
        8'hFF, 8'h0F, 8'hFF, 8'h0F, 8'hFF, 8'h0F, 8'h1F, 8'h3F,
        8'h1F, 8'h1F, 8'h1F, 8'hFF, 8'hFF, 8'h0F, 8'h00, 8'h00
    };

    // Each synchronizer stage carries {bdir, bc1, data_in[7:0]}.
    logic [9:0] sync_q [SYNC_STAGES];
    logic [9:0] sync_d [SYNC_STAGES];
    logic [7:0] regs_q [16];
    logic [7:0] regs_d [16];
    mode_e      state_q, state_d;
    mode_e      mode;
    logic [7:0] data_s;
    logic       entry;
    logic [3:0] addr_q, addr_d;
    logic       addr_valid_q, addr_valid_d;
    logic [7:0] data_out_q, data_out_d;
    logic       data_oe_q, data_oe_d;
    logic       env_restart_q, env_restart_d;
    logic       wr_strobe_q, wr_strobe_d;
    logic [3:0] wr_addr_q, wr_addr_d;
    logic [7:0] rd_data;

    assign mode    = mode_e'(sync_q[SYNC_STAGES-1][9:8]);
    assign data_s  = sync_q[SYNC_STAGES-1][7:0];
    // state_q is the mode seen last cycle, so any difference marks a phase entry.
    assign entry   = (mode != state_q);
    assign rd_data = (addr_q <= 4'd13) ? regs_q[addr_q] : 8'h00;

    always_comb begin
        sync_d[0] = {bus.bdir, bus.bc1, bus.data_in};
        for (int i = 1; i < SYNC_STAGES; i++) sync_d[i] = sync_q[i-1];
        state_d       = mode;
        regs_d        = regs_q;
        addr_d        = addr_q;
        addr_valid_d  = addr_valid_q;
        wr_strobe_d   = 1'b0;
        wr_addr_d     = wr_addr_q;
        env_restart_d = 1'b0;
        if (entry && mode == LATCH) begin
            addr_valid_d = (data_s[7:4] == CHIP_ADDR);
            addr_d       = (data_s[7:4] == CHIP_ADDR) ? data_s[3:0] : addr_q;
        end
        if (entry && mode == WRITE && addr_valid_q && addr_q <= 4'd13) begin
            regs_d[addr_q] = data_s & FIELD_MASK[addr_q];
            wr_strobe_d    = 1'b1;
            wr_addr_d      = addr_q;
            env_restart_d  = (addr_q == 4'd13);
        end
        // Read-back uses the stored (pre-write) value; a same-cycle write shows next cycle.
        data_oe_d  = (mode == READ) && addr_valid_q;
        data_out_d = (mode == READ) ? rd_data : 8'h00;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q        <= '{default: '0};
            regs_q        <= '{default: '0};
            state_q       <= INACTIVE;
            addr_q        <= 4'h0;
            addr_valid_q  <= 1'b0;
            data_out_q    <= 8'h00;
            data_oe_q     <= 1'b0;
            env_restart_q <= 1'b0;
            wr_strobe_q   <= 1'b0;
            wr_addr_q     <= 4'h0;
        end else begin
            sync_q        <= sync_d;
            regs_q        <= regs_d;
            state_q       <= state_d;
            addr_q        <= addr_d;
            addr_valid_q  <= addr_valid_d;
            data_out_q    <= data_out_d;
            data_oe_q     <= data_oe_d;
            env_restart_q <= env_restart_d;
            wr_strobe_q   <= wr_strobe_d;
            wr_addr_q     <= wr_addr_d;
        end
    end

    assign bus.data_out  = data_out_q;
    assign bus.data_oe   = data_oe_q;
    assign tone_period_a = {regs_q[1][3:0], regs_q[0]};
    assign tone_period_b = {regs_q[3][3:0], regs_q[2]};
    assign tone_period_c = {regs_q[5][3:0], regs_q[4]};
    assign noise_period  = regs_q[6][4:0];
    assign mixer_en_n    = regs_q[7][5:0];
    assign amp_a         = regs_q[8][4:0];
    assign amp_b         = regs_q[9][4:0];
    assign amp_c         = regs_q[10][4:0];
    assign env_period    = {regs_q[12], regs_q[11]};
    assign env_shape     = regs_q[13][3:0];
    assign env_restart   = env_restart_q;
    assign wr_strobe     = wr_strobe_q;
    assign wr_addr       = wr_addr_q;

endmodule

// File: tb/tb_ay8913_bus_interface.sv
// tb_ay8913_bus_interface: table-driven and scoreboarded bench for ay8913_bus_interface
module tb_ay8913_bus_interface;

    localparam int SS = 2;
    localparam int NH = SS + 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [11:0] tone_period_a, tone_period_b, tone_period_c;
    logic [4:0]  noise_period, amp_a, amp_b, amp_c;
    logic [5:0]  mixer_en_n;
    logic [15:0] env_period;
    logic [3:0]  env_shape, wr_addr;
    logic        env_restart, wr_strobe;

    ay8913_bus_interface_if bus ();

    ay8913_bus_interface #(.SYNC_STAGES(SS), .CHIP_ADDR(4'h0)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .bus           (bus),
        .tone_period_a (tone_period_a),
        .tone_period_b (tone_period_b),
        .tone_period_c (tone_period_c),
        .noise_period  (noise_period),
        .mixer_en_n    (mixer_en_n),
        .amp_a         (amp_a),
        .amp_b         (amp_b),
        .amp_c         (amp_c),
        .env_period    (env_period),
        .env_shape     (env_shape),
        .env_restart   (env_restart),
        .wr_strobe     (wr_strobe),
        .wr_addr       (wr_addr)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [7:0] a;
        logic [7:0] d;
        logic [7:0] rd;
        logic       oe;
        logic       w;
    } vec_t;

    typedef struct packed {
        logic [3:0] a;
        logic [7:0] d;
        logic       r;
    } sb_t;

    sb_t        sb_q[$];
    vec_t       vt [17];
    int         n_vec = 0;
    int         n_err = 0;
    int         restarts = 0;
    logic       prev_restart = 1'b0;
    logic       m_valid = 1'b0;
    logic [3:0] m_addr = 4'h0;

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    function automatic logic [7:0] out_field(input logic [3:0] a);
        case (a)
            4'd0:    return tone_period_a[7:0];
            4'd1:    return {4'h0, tone_period_a[11:8]};
            4'd2:    return tone_period_b[7:0];
            4'd3:    return {4'h0, tone_period_b[11:8]};
            4'd4:    return tone_period_c[7:0];
            4'd5:    return {4'h0, tone_period_c[11:8]};
            4'd6:    return {3'h0, noise_period};
            4'd7:    return {2'h0, mixer_en_n};
            4'd8:    return {3'h0, amp_a};
            4'd9:    return {3'h0, amp_b};
            4'd10:   return {3'h0, amp_c};
            4'd11:   return env_period[7:0];
            4'd12:   return env_period[15:8];
            4'd13:   return {4'h0, env_shape};
            default: return 8'h00;
        endcase
    endfunction

    task automatic phase(input logic [1:0] m, input logic [7:0] d, input int n);
        bus.bdir    = m[1];
        bus.bc1     = m[0];
        bus.data_in = d;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic lt(input logic [7:0] a);
        m_valid = (a[7:4] == 4'h0);
        if (m_valid) m_addr = a[3:0];
        phase(2'b11, a, NH);
    endtask

    task automatic push_wr(input logic [7:0] exp);
        if (m_valid && m_addr <= 4'd13) sb_q.push_back('{m_addr, exp, m_addr == 4'd13});
    endtask

    task automatic wr(input logic [7:0] d, input logic [7:0] exp);
        push_wr(exp);
        phase(2'b10, d, NH);
    endtask

    // Scoreboard: every strobe must match the oldest expected write.
    always @(negedge clk) begin
        if (rst_n) begin
            if (env_restart && !wr_strobe) chk("restart_without_strobe", 16'(env_restart), 16'(0));
            if (env_restart && prev_restart) chk("restart_width", 16'(env_restart), 16'(0));
            prev_restart = env_restart;
            if (wr_strobe) begin
                if (sb_q.size() == 0) chk("unexpected_strobe", {12'h0, wr_addr}, 16'hFFFF);
                else begin
                    sb_t e;
                    e = sb_q.pop_front();
                    chk("wr_addr", {12'h0, wr_addr}, {12'h0, e.a});
                    chk("wr_field", {8'h0, out_field(wr_addr)}, {8'h0, e.d});
                    chk("wr_restart", 16'(env_restart), 16'(e.r));
                    if (env_restart) restarts++;
                end
            end
        end else prev_restart = 1'b0;
    end

    initial begin
        int r0;
        vt = '{
            '{8'h00, 8'hAB, 8'hAB, 1'b1, 1'b1},
            '{8'h01, 8'hFC, 8'h0C, 1'b1, 1'b1},
            '{8'h02, 8'h34, 8'h34, 1'b1, 1'b1},
            '{8'h03, 8'hF1, 8'h01, 1'b1, 1'b1},
            '{8'h04, 8'h56, 8'h56, 1'b1, 1'b1},
            '{8'h05, 8'h27, 8'h07, 1'b1, 1'b1},
            '{8'h06, 8'hFF, 8'h1F, 1'b1, 1'b1},
            '{8'h07, 8'hFF, 8'h3F, 1'b1, 1'b1},
            '{8'h08, 8'h1F, 8'h1F, 1'b1, 1'b1},
            '{8'h09, 8'hE5, 8'h05, 1'b1, 1'b1},
            '{8'h0A, 8'h10, 8'h10, 1'b1, 1'b1},
            '{8'h0B, 8'h9A, 8'h9A, 1'b1, 1'b1},
            '{8'h0C, 8'hBC, 8'hBC, 1'b1, 1'b1},
            '{8'h0D, 8'hFE, 8'h0E, 1'b1, 1'b1},
            '{8'h17, 8'h55, 8'h00, 1'b0, 1'b0},
            '{8'h0E, 8'hFF, 8'h00, 1'b1, 1'b0},
            '{8'h0F, 8'h12, 8'h00, 1'b1, 1'b0}
        };
        bus.bdir = 1'b0;
        bus.bc1 = 1'b0;
        bus.data_in = 8'h00;
        #17;
        chk("rst_oe", 16'(bus.data_oe), 16'(0));
        chk("rst_dout", {8'h0, bus.data_out}, 16'h0);
        chk("rst_strobe", {11'h0, wr_strobe, wr_addr}, 16'h0);
        for (int i = 0; i < 14; i++) chk("rst_field", {8'h0, out_field(4'(i))}, 16'h0);
        @(negedge clk);
        rst_n = 1'b1;
        phase(2'b00, 8'h00, 3);

        // Latch straight into write; check pin-to-field latency and strobe timing.
        lt(8'h07);
        push_wr(8'h3F);
        bus.bdir = 1'b1;
        bus.bc1 = 1'b0;
        bus.data_in = 8'h3F;
        repeat (SS) @(posedge clk);
        #1;
        chk("lat_early", {10'h0, mixer_en_n}, 16'h0);
        chk("lat_early_strobe", 16'(wr_strobe), 16'(0));
        @(posedge clk);
        #1;
        chk("lat_mixer", {10'h0, mixer_en_n}, 16'h3F);
        chk("lat_strobe", {11'h0, wr_strobe, wr_addr}, {11'h1, 4'h7});
        @(posedge clk);
        #1;
        chk("lat_strobe_end", 16'(wr_strobe), 16'(0));
        phase(2'b10, 8'h3F, NH);
        phase(2'b00, 8'h00, NH);

        foreach (vt[i]) begin
            lt(vt[i].a);
            wr(vt[i].d, vt[i].rd);
            phase(2'b00, 8'h00, 2);
            if (vt[i].w) chk("tbl_field", {8'h0, out_field(vt[i].a[3:0])}, {8'h0, vt[i].rd});
            phase(2'b01, 8'h00, NH);
            chk("tbl_oe", 16'(bus.data_oe), 16'(vt[i].oe));
            if (vt[i].oe) chk("tbl_dout", {8'h0, bus.data_out}, {8'h0, vt[i].rd});
            phase(2'b00, 8'h00, NH);
            chk("idle_oe", {7'h0, bus.data_oe, bus.data_out}, 16'h0);
        end

        chk("tone_a", {4'h0, tone_period_a}, 16'h0CAB);
        chk("tone_b", {4'h0, tone_period_b}, 16'h0134);
        chk("tone_c", {4'h0, tone_period_c}, 16'h0756);
        chk("noise", {11'h0, noise_period}, 16'h001F);
        chk("amps", {1'b0, amp_a, amp_b, amp_c}, {1'b0, 5'h1F, 5'h05, 5'h10});
        chk("env_period", env_period, 16'hBC9A);

        // Two R13 writes of the same value, each a separate restart pulse.
        r0 = restarts;
        lt(8'h0D);
        wr(8'h0E, 8'h0E);
        phase(2'b00, 8'h00, NH);
        wr(8'h0E, 8'h0E);
        phase(2'b00, 8'h00, NH);
        chk("env_shape", {12'h0, env_shape}, 16'h000E);
        chk("restart_count", 16'(restarts - r0), 16'd2);

        // Reset in the middle of a held WRITE phase.
        lt(8'h08);
        push_wr(8'h1F);
        phase(2'b10, 8'h1F, NH);
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_amp", {11'h0, amp_a}, 16'h0);
        chk("mid_rst_tone", {4'h0, tone_period_a}, 16'h0);
        chk("mid_rst_env", env_period, 16'h0);
        chk("mid_rst_misc", {6'h0, env_restart, wr_strobe, bus.data_oe, bus.data_out}, 16'h0);
        m_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (NH) @(posedge clk);
        #1;
        chk("post_rst_amp", {11'h0, amp_a}, 16'h0);
        phase(2'b01, 8'h00, NH);
        chk("post_rst_oe", 16'(bus.data_oe), 16'(0));
        phase(2'b00, 8'h00, NH);
        chk("sb_empty", 16'(sb_q.size()), 16'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
